hlr_booth_seq_mul: RTL and testbench
====================================

Name: hlr_booth_seq_mul

Overview:
- Parametrised, iterative signed multiplier with a run-time choice of exact or approximate mode.
- Successor to the combinational 8x8 hybrid approximate Booth multiplier. It consumes one Booth group per clock instead of a full parallel array.
- Exact mode: radix-4 Booth. Approximate mode: R8ABE2 radix-8 low groups, exact radix-4 upper groups, and adders that drop carries from the low TRUNC_BITS.
- Sits behind a valid/ready stream in the approximate-arithmetic test bench datapath.

Parameters:
WIDTH, 8, operand width in bits; must be even and >= 4
NUM_R8, 2, number of low R8ABE2 radix-8 groups used in approx mode; WIDTH-3*NUM_R8 must be even and >= 0
TRUNC_BITS, 4, approx mode only: adder LSBs computed as XOR, with carry into bit TRUNC_BITS forced to 0; range 0..2*WIDTH

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand request
in_ready  output  1  block can accept operands (high only in IDLE)
in_x  input  WIDTH  signed multiplier (Booth-recoded)
in_y  input  WIDTH  signed multiplicand
in_approx  input  1  1 = approximate mode, 0 = exact mode; sampled at accept
out_valid  output  1  result available
out_ready  input  1  downstream accepts result
out_prod  output  2*WIDTH  signed product, low 2*WIDTH bits of the accumulator
out_approx  output  1  mode used to produce out_prod

Behaviour:
- Reset: state=IDLE; in_ready=1; out_valid=0; out_prod=0; out_approx=0; accumulator, counter and operand registers cleared. Reset mid-operation aborts the job; no result is emitted.
- States:
  - IDLE -> RUN on in_valid&&in_ready. Latch x, sign-extended y, and mode; acc=0; group index=0.
  - RUN: one partial product added per cycle. After the last group -> DONE.
  - DONE: out_valid=1, out_prod/out_approx held stable. out_valid&&out_ready -> IDLE.
  - No accept in DONE or RUN. in_ready is low there, and in_valid is ignored.
- Latency: G cycles from accept edge to first cycle with out_valid=1.
  - Exact mode: G = WIDTH/2.
  - Approx mode: G = NUM_R8 + (WIDTH-3*NUM_R8)/2.
  - WIDTH=8, NUM_R8=2: 4 exact, 3 approx.
- Recoding uses xz = {x, 1'b0}. Window at bit position p reads x[p-1] as 0 for p=0, and sign-extends x above WIDTH-1.
  - Exact: radix-4 windows {x[p+1],x[p],x[p-1]} at p=0,2,...,WIDTH-2.
  - Radix-4 digit map: 000/111->0; 001/010->+1; 011->+2; 100->-2; 101/110->-1.
  - Approx: radix-8 windows {x[p+2..p-1]} at p=0,3,...,3*(NUM_R8-1), then radix-4 windows at p=3*NUM_R8, +2, ... up to WIDTH-2.
  - R8ABE2 map:
    - 0000/1111->0; 0001/0010->+1; 0011/0100/0101->+2; 0110/0111->+4
    - 1000/1001->-4; 1010/1011/1100->-2; 1101/1110->-1
- Partial product = digit*y << p, sign-extended to 2*WIDTH+1 bits. Negation is two's complement (exact).
- Accumulation: acc = acc + pp on each RUN cycle.
  - Exact mode: full-width add.
  - Approx mode: acc[TRUNC_BITS-1:0] = acc^pp; upper bits use a normal add with carry-in 0 at bit TRUNC_BITS. Wrap modulo 2^(2*WIDTH+1).
  - Group order is ascending p. The first add is exact because acc=0.
- out_prod = acc[2*WIDTH-1:0], registered when entering DONE, and held through back-pressure of any length.
- in_approx is sampled only at the accept edge; changes during RUN/DONE have no effect.

Test Plan:
- Exact mode, W=8: x=7, y=7 -> out_prod=49 (0x0031), out_approx=0, out_valid exactly 4 cycles after accept. Also x=-128, y=-128 -> 0x4000; x=-128, y=127 -> 0xC080.
- Approx mode, W=8: x=5, y=10 -> 60 (0x003C); x=3, y=7 -> 28 (0x001C); out_valid exactly 3 cycles after accept.
- Approx carry-drop: x=9, y=15 -> 119 (0x0077); same operands in exact mode -> 135 (0x0087).
- Back-pressure: out_ready low 5 cycles in DONE -> out_valid stays 1, out_prod stable, in_ready=0, a new in_valid is ignored. out_ready high -> IDLE next cycle, then the next job is accepted.
- Reset mid-RUN: assert rst on cycle 2 of a job -> next cycle IDLE, out_valid=0, out_prod=0, in_ready=1. No stale result appears.
- Random sweep, W=8 and W=12 (NUM_R8=2): exact mode matches x*y for all sampled operands. Approx mode matches a bit-accurate model of the recoding and truncated add. in_approx toggled mid-RUN does not change the result.

Source files
------------

// File: rtl/hlr_booth_seq_mul.sv
// Iterative signed Booth multiplier, one partial product per clock.
// Exact radix-4, or approximate R8ABE2 low groups with carry-dropped low adder bits.
module hlr_booth_seq_mul #(
  parameter int WIDTH      = 8,
  parameter int NUM_R8     = 2,
  parameter int TRUNC_BITS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_x,
  input  logic [WIDTH-1:0]   in_y,
  input  logic               in_approx,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_prod,
  output logic               out_approx
);

  localparam int AW = 2*WIDTH+1;
  localparam int PW = $clog2(WIDTH+1);
  localparam logic [PW-1:0] POS_END = PW'(WIDTH);
  localparam logic [PW-1:0] R8_END  = PW'(3*NUM_R8);
  localparam logic [AW-1:0] LOW_MASK = ~({AW{1'b1}} << TRUNC_BITS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] x_r;
  logic [AW-1:0]    y_r;
  logic             approx_r;
  logic [AW-1:0]    acc;
  logic [PW-1:0]    pos;

  logic [WIDTH+1:0] xz;
  logic [3:0]       wnd;
  logic             r8;
  logic             neg;
  logic [1:0]       mag;
  logic [AW-1:0]    mult;
  logic [AW-1:0]    pp;
  logic [AW-1:0]    acc_nxt;
  logic [PW-1:0]    pos_nxt;
  logic             last;

  always_comb begin
    xz  = {x_r[WIDTH-1], x_r, 1'b0};
    wnd = xz[pos +: 4];
    r8  = approx_r && (pos < R8_END);
  end

  // mag: 0 -> 0, 1 -> y, 2 -> 2y, 3 -> 4y
  always_comb begin
    mag = 2'd0;
    neg = 1'b0;
    if (r8) begin
      unique case (wnd)
        4'b0001, 4'b0010:          mag = 2'd1;
        4'b0011, 4'b0100, 4'b0101: mag = 2'd2;
        4'b0110, 4'b0111:          mag = 2'd3;
        4'b1000, 4'b1001: begin
          mag = 2'd3;
          neg = 1'b1;
        end
        4'b1010, 4'b1011, 4'b1100: begin
          mag = 2'd2;
          neg = 1'b1;
        end
        4'b1101, 4'b1110: begin
          mag = 2'd1;
          neg = 1'b1;
        end
        default: ;
      endcase
    end else begin
      unique case (wnd[2:0])
        3'b001, 3'b010: mag = 2'd1;
        3'b011:         mag = 2'd2;
        3'b100: begin
          mag = 2'd2;
          neg = 1'b1;
        end
        3'b101, 3'b110: begin
          mag = 2'd1;
          neg = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    unique case (mag)
      2'd1:    mult = y_r;
      2'd2:    mult = y_r << 1;
      2'd3:    mult = y_r << 2;
      default: mult = '0;
    endcase
    pp = (neg ? -mult : mult) << pos;
  end

  // Masking the low lanes out of the add keeps any carry from reaching TRUNC_BITS.
  always_comb begin
    if (approx_r) begin
      acc_nxt = ((acc & ~LOW_MASK) + (pp & ~LOW_MASK))
              | ((acc ^ pp) & LOW_MASK);
    end else begin
      acc_nxt = acc + pp;
    end
    pos_nxt = pos + (r8 ? PW'(3) : PW'(2));
    last    = (pos_nxt == POS_END);
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (in_valid) state_nxt = RUN;
      RUN:  if (last) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_r        <= '0;
      y_r        <= '0;
      approx_r   <= 1'b0;
      acc        <= '0;
      pos        <= '0;
      out_prod   <= '0;
      out_approx <= 1'b0;
    end else begin
      if (state == IDLE && in_valid) begin
        x_r      <= in_x;
        y_r      <= {{(WIDTH+1){in_y[WIDTH-1]}}, in_y};
        approx_r <= in_approx;
        acc      <= '0;
        pos      <= '0;
      end
      if (state == RUN) begin
        acc <= acc_nxt;
        pos <= pos_nxt;
        if (last) begin
          out_prod   <= acc_nxt[2*WIDTH-1:0];
          out_approx <= approx_r;
        end
      end
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

endmodule

// File: tb/tb_hlr_booth_seq_mul.sv
// Scoreboard bench for hlr_booth_seq_mul at WIDTH=8 and WIDTH=12.
// Arithmetic reference model; monitors pop expected results on handshake.
module tb_hlr_booth_seq_mul;

  localparam int NR8 = 2;
  localparam int TB  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  in_valid;
  logic [1:0]  in_approx;
  logic [1:0]  out_ready;
  logic [7:0]  x0, y0;
  logic [11:0] x1, y1;
  logic        ir0, ir1, ov0, ov1, oa0, oa1;
  logic [15:0] prod0;
  logic [23:0] prod1;

  wire [1:0] in_ready   = {ir1, ir0};
  wire [1:0] out_valid  = {ov1, ov0};
  wire [1:0] out_approx = {oa1, oa0};

  hlr_booth_seq_mul #(.WIDTH(8), .NUM_R8(NR8), .TRUNC_BITS(TB)) u8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(ir0),
    .in_x(x0), .in_y(y0), .in_approx(in_approx[0]),
    .out_valid(ov0), .out_ready(out_ready[0]),
    .out_prod(prod0), .out_approx(oa0)
  );

  hlr_booth_seq_mul #(.WIDTH(12), .NUM_R8(NR8), .TRUNC_BITS(TB)) u12 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(ir1),
    .in_x(x1), .in_y(y1), .in_approx(in_approx[1]),
    .out_valid(ov1), .out_ready(out_ready[1]),
    .out_prod(prod1), .out_approx(oa1)
  );

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    longint prod;
    bit     ap;
    longint acc_cyc;
    int     lat;
  } exp_t;

  exp_t q[2][$];
  bit   seen[2];

  task automatic chk(string n, longint a, longint e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", n, a, e);
    end
  endtask

  function automatic int xb(longint x, int w, int i);
    if (i < 0) return 0;
    if (i >= w) i = w - 1;
    return int'((x >> i) & 1);
  endfunction

  // Multiply by summing recoded digits times y, with optional carry-dropping add
  function automatic longint model(int w, longint x, longint y, bit ap);
    int     tab[16] = '{0, 1, 1, 2, 2, 2, 4, 4, -4, -4, -2, -2, -2, -1, -1, 0};
    longint am = (longint'(1) << (2*w+1)) - 1;
    longint tm = (longint'(1) << TB) - 1;
    longint acc = 0;
    longint pp;
    int     p = 0;
    int     d;
    int     step;
    while (p < w) begin
      if (ap && p < 3*NR8) begin
        d = tab[xb(x,w,p+2)*8 + xb(x,w,p+1)*4 + xb(x,w,p)*2 + xb(x,w,p-1)];
        step = 3;
      end else begin
        d = xb(x,w,p-1) + xb(x,w,p) - 2*xb(x,w,p+1);
        step = 2;
      end
      pp = (longint'(d) * y * (longint'(1) << p)) & am;
      if (ap)
        acc = ((((acc >> TB) + (pp >> TB)) << TB) | ((acc ^ pp) & tm)) & am;
      else
        acc = (acc + pp) & am;
      p += step;
    end
    return acc & ((longint'(1) << (2*w)) - 1);
  endfunction

  function automatic longint rnd_s(int w);
    longint v = longint'($urandom_range(0, (1 << w) - 1));
    if (v >= (longint'(1) << (w-1))) v -= longint'(1) << w;
    return v;
  endfunction

  function automatic longint prod_of(int l);
    return (l == 0) ? longint'(prod0) : longint'(prod1);
  endfunction

  task automatic mon(int l);
    exp_t e;
    if (rst) begin
      seen[l] = 1'b0;
      return;
    end
    if (!out_valid[l]) return;
    if (q[l].size() == 0) begin
      chk($sformatf("spurious_valid[%0d]", l), longint'(out_valid[l]), 0);
      return;
    end
    e = q[l][0];
    if (!seen[l]) begin
      chk($sformatf("latency[%0d]", l), cyc - e.acc_cyc, longint'(e.lat));
      chk($sformatf("mode[%0d]", l), longint'(out_approx[l]), longint'(e.ap));
      seen[l] = 1'b1;
    end
    chk($sformatf("prod[%0d]", l), prod_of(l), e.prod);
    chk($sformatf("in_ready_busy[%0d]", l), longint'(in_ready[l]), 0);
    if (out_ready[l]) begin
      void'(q[l].pop_front());
      seen[l] = 1'b0;
    end
  endtask

  always @(negedge clk) mon(0);
  always @(negedge clk) mon(1);

  task automatic set_ops(int l, longint x, longint y);
    if (l == 0) begin
      x0 = x[7:0];
      y0 = y[7:0];
    end else begin
      x1 = x[11:0];
      y1 = y[11:0];
    end
  endtask

  task automatic start_job(int l, longint x, longint y, bit ap,
                           longint ex, int lat);
    int n = 0;
    @(posedge clk); #1;
    while (!in_ready[l] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready[l]) begin
      chk($sformatf("accept_timeout[%0d]", l), longint'(in_ready[l]), 1);
      return;
    end
    set_ops(l, x, y);
    in_approx[l] = ap;
    in_valid[l]  = 1'b1;
    @(posedge clk); #1;
    in_valid[l] = 1'b0;
    q[l].push_back('{ex, ap, cyc, lat});
  endtask

  // Flip in_approx every cycle so a mid-run change would corrupt the result
  task automatic drain(int l, bit rnd);
    for (int n = 0; n < 200 && q[l].size() != 0; n++) begin
      @(posedge clk); #1;
      in_approx[l] = 1'($urandom);
      if (rnd) out_ready[l] = 1'($urandom);
    end
    out_ready[l] = 1'b1;
    if (q[l].size() != 0) begin
      chk($sformatf("drain_timeout[%0d]", l), longint'(q[l].size()), 0);
      q[l].delete();
    end
  endtask

  longint dx[7]  = '{7, -128, -128, 5, 3, 9, 9};
  longint dy[7]  = '{7, -128, 127, 10, 7, 15, 15};
  bit     dap[7] = '{0, 0, 0, 1, 1, 1, 0};
  longint dex[7] = '{'h0031, 'h4000, 'hC080, 'h003C, 'h001C, 'h0077, 'h0087};
  int     dlat[7] = '{4, 4, 4, 3, 3, 3, 4};

  initial begin
    #500000;
    $display("FAIL global_timeout: got %0d cycles, want completion", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    longint x, y, ex;
    bit     ap;
    int     w, n;

    rst       = 1'b1;
    in_valid  = '0;
    in_approx = '0;
    out_ready = 2'b11;
    set_ops(0, 0, 0);
    set_ops(1, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    for (int l = 0; l < 2; l++) begin
      chk($sformatf("rst_in_ready[%0d]", l), longint'(in_ready[l]), 1);
      chk($sformatf("rst_out_valid[%0d]", l), longint'(out_valid[l]), 0);
      chk($sformatf("rst_out_approx[%0d]", l), longint'(out_approx[l]), 0);
      chk($sformatf("rst_out_prod[%0d]", l), prod_of(l), 0);
    end
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      start_job(0, dx[i], dy[i], dap[i], dex[i], dlat[i]);
      drain(0, 1'b0);
    end

    // Back-pressure: hold the result, offer a competing request meanwhile
    out_ready[0] = 1'b0;
    start_job(0, -77, 53, 1'b0, 'hF00F, 4);
    n = 0;
    while (!out_valid[0] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_valid_seen", longint'(out_valid[0]), 1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", longint'(in_ready[0]), 0);
      set_ops(0, 1, 1);
      in_valid[0] = 1'b1;
      @(posedge clk); #1;
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle_ready", longint'(in_ready[0]), 1);
    chk("bp_idle_valid", longint'(out_valid[0]), 0);
    chk("bp_queue_empty", longint'(q[0].size()), 0);
    start_job(0, 11, -3, 1'b1, model(8, 11, -3, 1'b1), 3);
    drain(0, 1'b0);

    // Reset during the second RUN cycle drops the job
    start_job(0, 100, 100, 1'b0, 'h2710, 4);
    @(posedge clk); #1;
    rst = 1'b1;
    q[0].delete();
    @(posedge clk); #1;
    chk("midrst_in_ready", longint'(in_ready[0]), 1);
    chk("midrst_out_valid", longint'(out_valid[0]), 0);
    chk("midrst_out_prod", prod_of(0), 0);
    rst = 1'b0;
    repeat (8) @(posedge clk);

    for (int l = 0; l < 2; l++) begin
      w = (l == 0) ? 8 : 12;
      for (int k = 0; k < 40; k++) begin
        x  = rnd_s(w);
        y  = rnd_s(w);
        ap = 1'($urandom);
        ex = model(w, x, y, ap);
        if (!ap) ex = (x * y) & ((longint'(1) << (2*w)) - 1);
        start_job(l, x, y, ap, ex, ap ? NR8 + (w - 3*NR8)/2 : w/2);
        drain(l, 1'b1);
      end
    end

    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
